// File: rtl/mc_controller_v2.sv
// rtl/mc_controller_v2.sv - multi-cycle MIPS control unit with memory handshake and sticky faults
module mc_controller_v2 #(
    parameter int MEM_TIMEOUT = 16,
    parameter bit HAS_JAL     = 1'b1,
    parameter int CNT_WIDTH   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       memread_o,
    output logic       memwrite_o,
    output logic       mem_word_o,
    output logic       iord_o,
    output logic       irwrite_o,
    output logic       pcen_o,
    output logic [1:0] pcsource_o,
    output logic       alusrca_o,
    output logic [2:0] alusrcb_o,
    output logic [1:0] aluop_o,
    output logic       regwrite_o,
    output logic [1:0] regdst_o,
    output logic [1:0] memtoreg_o,
    output logic       illegal_op_o,
    output logic       bus_err_o,
    output logic [3:0] state_o
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LB   = 6'b100000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SB   = 6'b101000;
    localparam logic [5:0] OP_SW   = 6'b101011;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BEQEX  = 4'd8,
        S_BNEEX  = 4'd9,
        S_JEX    = 4'd10,
        S_JALEX  = 4'd11,
        S_IEX    = 4'd12,
        S_IWB    = 4'd13,
        S_TRAP   = 4'd14
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] wait_cnt;
    logic                 illegal_q;
    logic                 bus_err_q;
    logic                 mem_state;
    logic                 timeout;

    // Memory-waiting states share one counter; the last allowed cycle without ready is a timeout
    always_comb begin
        mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
        timeout   = mem_state && !mem_ready_i &&
                    (wait_cnt == CNT_WIDTH'(MEM_TIMEOUT - 1));
    end

    // State sequencing, wait counter and sticky fault flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_FETCH;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            wait_cnt <= (mem_state && !mem_ready_i && !timeout) ? wait_cnt + 1'b1 : '0;
            if (timeout) begin
                state     <= S_TRAP;
                bus_err_q <= 1'b1;
            end else begin
                case (state)
                    S_FETCH:  if (mem_ready_i) state <= S_DECODE;
                    S_DECODE: begin
                        case (op_i)
                            OP_LB, OP_LW, OP_SB, OP_SW: state <= S_MEMADR;
                            OP_R:                       state <= S_RTEX;
                            OP_BEQ:                     state <= S_BEQEX;
                            OP_BNE:                     state <= S_BNEEX;
                            OP_J:                       state <= S_JEX;
                            OP_JAL: begin
                                if (HAS_JAL) begin
                                    state <= S_JALEX;
                                end else begin
                                    state     <= S_TRAP;
                                    illegal_q <= 1'b1;
                                end
                            end
                            OP_ADDI, OP_ANDI, OP_ORI:   state <= S_IEX;
                            default: begin
                                state     <= S_TRAP;
                                illegal_q <= 1'b1;
                            end
                        endcase
                    end
                    S_MEMADR: state <= (op_i == OP_LB || op_i == OP_LW) ? S_MEMRD : S_MEMWR;
                    S_MEMRD:  if (mem_ready_i) state <= S_MEMWB;
                    S_MEMWB:  state <= S_FETCH;
                    S_MEMWR:  if (mem_ready_i) state <= S_FETCH;
                    S_RTEX:   state <= S_RTWB;
                    S_RTWB:   state <= S_FETCH;
                    S_BEQEX:  state <= S_FETCH;
                    S_BNEEX:  state <= S_FETCH;
                    S_JEX:    state <= S_FETCH;
                    S_JALEX:  state <= S_FETCH;
                    S_IEX:    state <= S_IWB;
                    S_IWB:    state <= S_FETCH;
                    S_TRAP:   state <= S_TRAP;
                    default: begin
                        state     <= S_TRAP;
                        illegal_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Datapath controls decoded from the current state; everything held at 0 while in reset
    always_comb begin
        memread_o    = 1'b0;
        memwrite_o   = 1'b0;
        mem_word_o   = 1'b0;
        iord_o       = 1'b0;
        irwrite_o    = 1'b0;
        pcen_o       = 1'b0;
        pcsource_o   = 2'b00;
        alusrca_o    = 1'b0;
        alusrcb_o    = 3'b000;
        aluop_o      = 2'b00;
        regwrite_o   = 1'b0;
        regdst_o     = 2'b00;
        memtoreg_o   = 2'b00;
        illegal_op_o = 1'b0;
        bus_err_o    = 1'b0;
        state_o      = 4'd0;
        if (rst) begin
            state_o      = state;
            illegal_op_o = illegal_q;
            bus_err_o    = bus_err_q;
            case (state)
                S_FETCH: begin
                    memread_o  = 1'b1;
                    mem_word_o = 1'b1;
                    alusrcb_o  = 3'b001;
                    irwrite_o  = mem_ready_i;
                    pcen_o     = mem_ready_i;
                end
                S_DECODE: alusrcb_o = 3'b011;
                S_MEMADR: begin
                    alusrca_o = 1'b1;
                    alusrcb_o = 3'b010;
                end
                S_MEMRD: begin
                    memread_o  = 1'b1;
                    iord_o     = 1'b1;
                    mem_word_o = (op_i == OP_LW);
                end
                S_MEMWB: begin
                    regwrite_o = 1'b1;
                    memtoreg_o = 2'b01;
                end
                S_MEMWR: begin
                    memwrite_o = 1'b1;
                    iord_o     = 1'b1;
                    mem_word_o = (op_i == OP_SW);
                end
                S_RTEX: begin
                    alusrca_o = 1'b1;
                    aluop_o   = 2'b10;
                end
                S_RTWB: begin
                    regwrite_o = 1'b1;
                    regdst_o   = 2'b01;
                end
                S_BEQEX, S_BNEEX: begin
                    alusrca_o  = 1'b1;
                    aluop_o    = 2'b01;
                    pcsource_o = 2'b01;
                    pcen_o     = (state == S_BEQEX) ? zero_i : !zero_i;
                end
                S_JEX: begin
                    pcsource_o = 2'b10;
                    pcen_o     = 1'b1;
                end
                S_JALEX: begin
                    pcsource_o = 2'b10;
                    pcen_o     = 1'b1;
                    regwrite_o = 1'b1;
                    regdst_o   = 2'b10;
                    memtoreg_o = 2'b10;
                end
                S_IEX: begin
                    alusrca_o = 1'b1;
                    if (op_i == OP_ADDI) begin
                        alusrcb_o = 3'b010;
                        aluop_o   = 2'b00;
                    end else begin
                        alusrcb_o = 3'b100;
                        aluop_o   = 2'b11;
                    end
                end
                S_IWB: regwrite_o = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
